// File: rtl/stream_pkg.sv
// Shared definitions for the byte-stream framing blocks: FSM states and
// common constants.
package stream_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CHAN,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         ERR_CNT_W         = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Recovers SYNC/CHAN/LEN/payload/CSUM framing from a byte stream and routes
// each payload to one of NUM_CH channels.
module stream_demux
  import stream_pkg::*;
#(
  parameter  int         NUM_CH    = 4,
  parameter  logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  localparam int         CH_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           stream_data,
  input  logic                 stream_valid,
  input  logic [NUM_CH-1:0]    ch_enable,
  output logic [7:0]           out_data,
  output logic [NUM_CH-1:0]    out_en,
  output logic [CH_W-1:0]      out_ch,
  output logic                 pkt_start,
  output logic                 pkt_end,
  output logic                 pkt_err,
  output logic                 sync_locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [8:0] NUM_CH_B = 9'(NUM_CH);

  state_t            state;
  logic [7:0]        in_data;
  logic              in_valid;
  logic [NUM_CH-1:0] in_enable;
  logic [CH_W-1:0]   chan;
  logic              chan_en;
  logic [7:0]        count;
  logic [7:0]        csum;
  logic              first;
  logic              id_bad;
  logic              csum_bad;
  logic              err_inc;

  // Accepted bytes (with the enables seen alongside them) are captured here
  // first, so the framing FSM works one cycle behind the input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_data   <= '0;
      in_valid  <= 1'b0;
      in_enable <= '0;
    end else begin
      in_data   <= stream_data;
      in_valid  <= stream_valid;
      in_enable <= ch_enable;
    end
  end

  assign id_bad   = ({1'b0, in_data} >= NUM_CH_B);
  assign csum_bad = (in_data != csum);
  assign err_inc  = in_valid && (((state == ST_CHAN) && id_bad) ||
                                 ((state == ST_CSUM) && csum_bad));

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HUNT;
      chan        <= '0;
      chan_en     <= 1'b0;
      count       <= '0;
      csum        <= '0;
      first       <= 1'b0;
      out_data    <= '0;
      out_en      <= '0;
      out_ch      <= '0;
      pkt_start   <= 1'b0;
      pkt_end     <= 1'b0;
      pkt_err     <= 1'b0;
      sync_locked <= 1'b0;
    end else begin
      out_en    <= '0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      pkt_err   <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_HUNT: begin
            if (in_data == SYNC_BYTE) state <= ST_CHAN;
          end
          ST_CHAN: begin
            if (id_bad) begin
              sync_locked <= 1'b0;
              state       <= ST_HUNT;
            end else begin
              chan    <= in_data[CH_W-1:0];
              out_ch  <= in_data[CH_W-1:0];
              chan_en <= in_enable[in_data[CH_W-1:0]];
              csum    <= in_data;
              state   <= ST_LEN;
            end
          end
          ST_LEN: begin
            count <= in_data;
            csum  <= csum ^ in_data;
            first <= 1'b1;
            state <= (in_data == 8'd0) ? ST_CSUM : ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            csum  <= csum ^ in_data;
            count <= count - 8'd1;
            first <= 1'b0;
            // Disabled channels still consume the payload to keep framing.
            if (chan_en) begin
              out_data  <= in_data;
              out_en    <= NUM_CH'(1) << chan;
              pkt_start <= first;
            end
            if (count == 8'd1) state <= ST_CSUM;
          end
          ST_CSUM: begin
            pkt_end     <= 1'b1;
            pkt_err     <= csum_bad;
            sync_locked <= !csum_bad;
            state       <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: packets are modelled at the frame level
// and the expected beats/ends are compared as the DUT emits them.
module tb_stream_demux;

  localparam int NUM_CH = 4;

  typedef struct {
    logic [3:0] en;
    logic [7:0] data;
    logic       start;
  } beat_t;

  typedef struct {
    logic [1:0] ch;
    logic       err;
  } end_t;

  logic        clk;
  logic        rst;
  logic [7:0]  stream_data;
  logic        stream_valid;
  logic [3:0]  ch_enable;
  logic [7:0]  out_data;
  logic [3:0]  out_en;
  logic [1:0]  out_ch;
  logic        pkt_start;
  logic        pkt_end;
  logic        pkt_err;
  logic        sync_locked;
  logic [15:0] err_count;

  logic        sc_inc;
  logic [3:0]  sc_count;

  beat_t exp_beats[$];
  end_t  exp_ends[$];
  beat_t mon_bt;
  end_t  mon_et;

  int   checks = 0;
  int   errors = 0;
  int   model_err = 0;
  logic model_sync = 1'b0;
  logic mon_on = 1'b0;

  stream_demux #(.NUM_CH(NUM_CH), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .ch_enable    (ch_enable),
    .out_data     (out_data),
    .out_en       (out_en),
    .out_ch       (out_ch),
    .pkt_start    (pkt_start),
    .pkt_end      (pkt_end),
    .pkt_err      (pkt_err),
    .sync_locked  (sync_locked),
    .err_count    (err_count)
  );

  sat_counter #(.WIDTH(4)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .inc   (sc_inc),
    .count (sc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard whenever a beat or end appears.
  always @(negedge clk) begin
    if (mon_on) begin
      if (out_en !== 4'b0000) begin
        checks++;
        if (exp_beats.size() == 0) begin
          errors++;
          $display("[TB] FAIL beat: got out_en=%b data=%h start=%b, required no beat", out_en, out_data, pkt_start);
        end else begin
          mon_bt = exp_beats.pop_front();
          if (out_en !== mon_bt.en || out_data !== mon_bt.data || pkt_start !== mon_bt.start) begin
            errors++;
            $display("[TB] FAIL beat: got en=%b data=%h start=%b, required en=%b data=%h start=%b",
                     out_en, out_data, pkt_start, mon_bt.en, mon_bt.data, mon_bt.start);
          end
        end
      end else if (pkt_start !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pkt_start: got %b without out_en, required 0", pkt_start);
      end
      if (pkt_end !== 1'b0) begin
        checks++;
        if (exp_ends.size() == 0) begin
          errors++;
          $display("[TB] FAIL pkt_end: got pkt_end=%b ch=%0d err=%b, required none", pkt_end, out_ch, pkt_err);
        end else begin
          mon_et = exp_ends.pop_front();
          if (out_ch !== mon_et.ch || pkt_err !== mon_et.err) begin
            errors++;
            $display("[TB] FAIL pkt_end: got ch=%0d err=%b, required ch=%0d err=%b", out_ch, pkt_err, mon_et.ch, mon_et.err);
          end
        end
      end else if (pkt_err !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pkt_err: got %b without pkt_end, required 0", pkt_err);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      stream_valid = 1'b0;
      stream_data  = 8'($urandom);
    end
    @(negedge clk);
    stream_data  = b;
    stream_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stream_valid = 1'b0;
    end
  endtask

  task automatic bump_err();
    if (model_err < 65535) model_err++;
  endtask

  task automatic send_packet(input logic [7:0] chan_byte, input int len, input logic [7:0] base,
                             input logic [7:0] step, input logic bad_csum, input int gap_max,
                             input logic flip_en);
    logic [7:0] b;
    logic [7:0] sum;
    logic       en;
    beat_t      bt;
    end_t       et;
    send_byte(8'hA5, gap_max);
    send_byte(chan_byte, gap_max);
    if (chan_byte >= 8'(NUM_CH)) begin
      bump_err();
      model_sync = 1'b0;
      return;
    end
    en = ch_enable[chan_byte[1:0]];
    if (flip_en) #1 ch_enable = ~ch_enable;
    sum = chan_byte ^ 8'(len);
    b   = base;
    for (int i = 0; i < len; i++) begin
      sum ^= b;
      if (en) begin
        bt.en    = 4'b0001 << chan_byte[1:0];
        bt.data  = b;
        bt.start = (i == 0);
        exp_beats.push_back(bt);
      end
      b += step;
    end
    et.ch  = chan_byte[1:0];
    et.err = bad_csum;
    exp_ends.push_back(et);
    if (bad_csum) begin
      bump_err();
      model_sync = 1'b0;
    end else begin
      model_sync = 1'b1;
    end
    send_byte(8'(len), gap_max);
    b = base;
    for (int i = 0; i < len; i++) begin
      send_byte(b, gap_max);
      b += step;
    end
    send_byte(bad_csum ? (sum ^ 8'hFD) : sum, gap_max);
    if (flip_en) #1 ch_enable = ~ch_enable;
  endtask

  task automatic drain_and_check(input string name);
    idle(4);
    checks++;
    if (exp_beats.size() != 0 || exp_ends.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s drain: got %0d beats/%0d ends outstanding, required 0/0", name, exp_beats.size(), exp_ends.size());
    end
    checks++;
    if (err_count !== 16'(model_err)) begin
      errors++;
      $display("[TB] FAIL %s err_count: got %h, required %h", name, err_count, 16'(model_err));
    end
    checks++;
    if (sync_locked !== model_sync) begin
      errors++;
      $display("[TB] FAIL %s sync_locked: got %b, required %b", name, sync_locked, model_sync);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    stream_valid = 1'b0;
    stream_data  = 8'h00;
    ch_enable    = 4'b1111;
    sc_inc       = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_data, out_en, out_ch, pkt_start, pkt_end, pkt_err, sync_locked, err_count, sc_count} !== 42'd0) begin
      errors++;
      $display("[TB] FAIL reset: got data=%h en=%b ch=%0d st=%b end=%b err=%b lock=%b cnt=%h sat=%h, required all 0",
               out_data, out_en, out_ch, pkt_start, pkt_end, pkt_err, sync_locked, err_count, sc_count);
    end
    rst    = 1'b1;
    mon_on = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    send_packet(8'h01, 3, 8'h10, 8'h10, 1'b0, 0, 1'b0);
    drain_and_check("basic");
  endtask

  task automatic test_bad_csum();
    send_packet(8'h01, 3, 8'h10, 8'h10, 1'b1, 0, 1'b0);
    drain_and_check("bad_csum");
  endtask

  task automatic test_bad_id();
    send_packet(8'h07, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    send_packet(8'h02, 2, 8'h40, 8'h01, 1'b0, 0, 1'b0);
    drain_and_check("bad_id");
  endtask

  task automatic test_disabled();
    ch_enable = 4'b1101;
    send_packet(8'h01, 2, 8'h55, 8'h03, 1'b0, 0, 1'b0);
    send_packet(8'h00, 3, 8'h0A, 8'h0B, 1'b0, 0, 1'b0);
    ch_enable = 4'b1111;
    drain_and_check("disabled");
  endtask

  task automatic test_gaps();
    send_packet(8'h03, 4, 8'hA5, 8'h11, 1'b0, 3, 1'b0);
    send_packet(8'h00, 0, 8'h00, 8'h00, 1'b0, 2, 1'b0);
    send_packet(8'h01, 3, 8'h10, 8'h10, 1'b0, 4, 1'b0);
    drain_and_check("gaps");
  endtask

  task automatic test_back_to_back();
    send_packet(8'h00, 2, 8'hC0, 8'h01, 1'b0, 0, 1'b0);
    send_packet(8'h02, 3, 8'h21, 8'h07, 1'b0, 0, 1'b1);
    send_packet(8'h03, 1, 8'hA5, 8'h00, 1'b1, 0, 1'b0);
    send_packet(8'h01, 2, 8'h99, 8'h02, 1'b0, 0, 1'b0);
    drain_and_check("back_to_back");
  endtask

  task automatic test_error_burst();
    for (int i = 0; i < 30; i++) begin
      send_packet(8'h04 + 8'(i % 8), 0, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    end
    drain_and_check("error_burst");
  endtask

  task automatic test_saturation();
    @(negedge clk);
    sc_inc = 1'b1;
    repeat (5) @(negedge clk);
    sc_inc = 1'b0;
    checks++;
    if (sc_count !== 4'd5) begin
      errors++;
      $display("[TB] FAIL sat_mid: got %h, required 5", sc_count);
    end
    sc_inc = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (sc_count !== 4'hF) begin
      errors++;
      $display("[TB] FAIL sat_hold: got %h, required F", sc_count);
    end
    sc_inc = 1'b0;
  endtask

  task automatic test_reset_mid();
    mon_on = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h05, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    @(negedge clk);
    stream_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_data, out_en, out_ch, pkt_start, pkt_end, pkt_err, sync_locked, err_count} !== 38'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got data=%h en=%b ch=%0d st=%b end=%b err=%b lock=%b cnt=%h, required all 0",
               out_data, out_en, out_ch, pkt_start, pkt_end, pkt_err, sync_locked, err_count);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_beats.delete();
    exp_ends.delete();
    model_err  = 0;
    model_sync = 1'b0;
    mon_on     = 1'b1;
    idle(2);
    send_packet(8'h01, 2, 8'h66, 8'h11, 1'b0, 0, 1'b0);
    drain_and_check("after_reset");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_id();
    test_disabled();
    test_gaps();
    test_back_to_back();
    test_error_burst();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised successor to the two-way video/misc stream splitter. Takes the same byte-wide `stream_data`/`stream_valid` input, recovers packet framing (sync, channel, length, payload, checksum), and routes each payload to one of `NUM_CH` output channels. Adds per-channel enables, checksum checking, resynchronisation after errors, and a saturating error counter. It sits directly behind the byte source and ahead of the per-channel consumers (video, misc, and future channels).

## Interface
- `NUM_CH`, default 4, number of output channels (2..16).
- `SYNC_BYTE`, default 8'hA5, packet sync marker.
- `CH_W`, derived as `$clog2(NUM_CH)`; this is a localparam, not overridable.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stream_data`  in  8  input byte.
- `stream_valid`  in  1  `stream_data` is valid this cycle. No backpressure exists.
- `ch_enable`  in  NUM_CH  per-channel enable. Sampled when the CHAN byte is accepted.
- `out_data`  out  8  payload byte, shared across all channels.
- `out_en`  out  NUM_CH  one-hot strobe qualifying `out_data` for a channel.
- `out_ch`  out  CH_W  channel of the current or most recent packet.
- `pkt_start`  out  1  pulses with the first payload strobe.
- `pkt_end`  out  1  pulses when the checksum byte has been checked.
- `pkt_err`  out  1  pulses together with `pkt_end` on a checksum mismatch.
- `sync_locked`  out  1  framing is trusted.
- `err_count`  out  16  saturating error count.

## Operation
- Frame format: SYNC, CHAN, LEN, LEN payload bytes, CSUM.
  - CSUM = CHAN ^ LEN ^ all payload bytes.
- A byte is accepted only when `stream_valid`=1. Gaps of any length are allowed anywhere; the FSM holds during a gap.
- FSM states: HUNT, CHAN, LEN, PAYLOAD, CSUM.
  - HUNT: on `SYNC_BYTE`, go to CHAN. Any other byte is discarded silently.
  - CHAN: if the byte is ≥ `NUM_CH`, treat it as an invalid id:
    - `err_count`+1, `sync_locked`←0, go to HUNT.
  - CHAN, valid id: latch the channel and `ch_enable[id]`, clear the running XOR to the CHAN byte, go to LEN.
  - LEN: latch the 8-bit count.
    - LEN=0 goes to CSUM.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: for each byte, XOR it into the running checksum and decrement the count.
    - If the channel is enabled, emit the byte.
    - When the count reaches 0, go to CSUM.
  - CSUM: compare the byte with the running XOR, assert `pkt_end`, and go to HUNT.
    - Mismatch: `pkt_err`=1, `err_count`+1, `sync_locked`←0.
    - Match: `sync_locked`←1.
- Disabled channel: the packet is fully consumed so framing is kept, but there is no `out_en` and no `pkt_start`. `pkt_end` and `pkt_err` are still reported.
- Payload already emitted is never retracted. Consumers use `pkt_err` to discard it.
- `err_count` saturates at 16'hFFFF and does not wrap.
- A SYNC-valued byte inside PAYLOAD or CSUM is data, not a resync.

## Timing
- Reset values: `out_data`=0, `out_en`=0, `out_ch`=0, `pkt_start`=0, `pkt_end`=0, `pkt_err`=0, `sync_locked`=0, `err_count`=0. FSM=HUNT, count=0, XOR=0.
- Latency: an input byte accepted at edge N appears on `out_data`/`out_en` after edge N+1. All outputs are registered.
- `out_en`, `pkt_start`, `pkt_end` and `pkt_err` are single-cycle pulses.
- `pkt_start` coincides with the first `out_en` of the packet. With LEN=0 there is no `pkt_start`.
- `pkt_end`/`pkt_err` assert one cycle after the CSUM byte is accepted. `out_ch` is stable while they are asserted.
- `out_data` holds its last value when `out_en`=0.
- Back-to-back packets are allowed: a SYNC may be accepted on the cycle immediately after CSUM.
- Changes to `ch_enable` in the middle of a packet have no effect until the next CHAN byte.
- Asserting `rst` in the middle of a packet aborts the packet immediately. No `pkt_end` is issued.

## Structure
- Shared package `stream_pkg` holds:
  - the FSM state enum;
  - `SYNC_BYTE_DEFAULT`;
  - the 16-bit error-count width constant.
- One sub-module, `sat_counter` (WIDTH parameter, increment input, saturates at all-ones). It is used for `err_count` and is reusable by other blocks.
- Target size: about 200 lines of RTL.

## Test plan
- Reset then the packet A5 01 03 10 20 30 (CSUM=01^03^10^20^30=02) 02:
  - expect `out_en`=4'b0010 for 3 cycles with data 10, 20, 30;
  - `pkt_start` with 10;
  - `pkt_end`=1, `pkt_err`=0, `sync_locked`=1.
- Same packet with CSUM=FF: payload is still emitted; then `pkt_end`=`pkt_err`=1, `err_count`=1, `sync_locked`=0.
- A5 07 (NUM_CH=4): `err_count`+1, return to HUNT. A following valid packet for ch2 is routed correctly.
- `ch_enable`=4'b1101 with a ch1 packet: no `out_en`, no `pkt_start`, `pkt_end`=1. The next ch0 packet is delivered.
- Random `stream_valid` gaps inside a packet, plus LEN=0 packet A5 00 00 00: output content is identical to the gap-free run. The LEN=0 packet gives `pkt_end` only.
- Force 70000 checksum errors: `err_count` holds at FFFF. Assert `rst` in the middle of a payload: all outputs are 0 immediately and the next SYNC is accepted.
